// File: rtl/press_classifier.sv
// press_classifier
//   Classifies presses of a debounced button into short, long and double
//   presses. Each classification is a one-cycle registered pulse, and
//   press_count keeps a wrapping count of all classified events.
//
// Ports
//   clk          : system clock, rising edge
//   n_reset      : asynchronous active-low reset
//   db_in        : debounced button level, synchronous to clk, 1 = pressed
//   short_press  : pulse, single short press classified
//   long_press   : pulse, hold reached LONG_CYCLES
//   double_press : pulse, second press started inside the DCLICK window
//   press_count  : 8-bit wrapping count of classified events
//   busy         : high while the classifier is not IDLE
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | button released, no event pending
// PRESSED      | button held, timing toward a long press
// WAIT_SECOND  | released after a short hold, timing the double window
// WAIT_RELEASE | event already emitted, waiting for the button to release
module press_classifier #(
    parameter logic [15:0] LONG_CYCLES   = 16'd1000,
    parameter logic [15:0] DCLICK_CYCLES = 16'd250
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       db_in,
    output logic       short_press,
    output logic       long_press,
    output logic       double_press,
    output logic [7:0] press_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        WAIT_SECOND  = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        db_q;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        double_q, double_d;
    logic [7:0]  count_q, count_d;
    logic        busy_q, busy_d;

    logic rise, fall;
    logic long_hit, window_end;

    assign rise       = db_in & ~db_q;
    assign fall       = ~db_in & db_q;
    assign long_hit   = (timer_q == (LONG_CYCLES - 16'd1));
    assign window_end = (timer_q == (DCLICK_CYCLES - 16'd1));

    // State register and all output flops
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            timer_q  <= 16'd0;
            db_q     <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            count_q  <= 8'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            db_q     <= db_in;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and timer
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    timer_d = 16'd0;
                end
            end
            PRESSED: begin
                // A release on the same edge as the long threshold wins.
                if (fall) begin
                    state_d = WAIT_SECOND;
                    timer_d = 16'd0;
                end else if (db_in && long_hit) begin
                    state_d = WAIT_RELEASE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            WAIT_SECOND: begin
                // A second press on the last window cycle still counts.
                if (rise) begin
                    state_d = WAIT_RELEASE;
                    timer_d = 16'd0;
                end else if (window_end) begin
                    state_d = IDLE;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            WAIT_RELEASE: begin
                timer_d = 16'd0;
                if (!db_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 16'd0;
            end
        endcase
    end

    // Outputs: pulses are raised by the same edge that performs the transition
    always_comb begin
        short_d  = (state_q == WAIT_SECOND) && !rise && window_end;
        long_d   = (state_q == PRESSED) && !fall && db_in && long_hit;
        double_d = (state_q == WAIT_SECOND) && rise;
        count_d  = count_q + {7'd0, (short_d | long_d | double_d)};
        busy_d   = (state_d != IDLE);
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign press_count  = count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

    localparam int LONG = 1000;
    localparam int DCK  = 250;

    logic       clk;
    logic       n_reset;
    logic       db_in;
    logic       short_press;
    logic       long_press;
    logic       double_press;
    logic [7:0] press_count;
    logic       busy;

    int passed = 0;
    int total  = 0;

    // Per-scenario history: db_in sampled at each edge, observed and expected
    // pulses as (edge index, kind) with kind 1=short 2=long 3=double.
    bit   samp[$];
    int   obs_e[$];
    int   obs_k[$];
    int   exp_e[$];
    int   exp_k[$];
    int   multi_hot;
    logic [7:0] exp_count;

    press_classifier #(
        .LONG_CYCLES  (16'(LONG)),
        .DCLICK_CYCLES(16'(DCK))
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .db_in       (db_in),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .press_count (press_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic begin_scn();
        samp.delete();
        obs_e.delete();
        obs_k.delete();
        multi_hot = 0;
    endtask

    task automatic step(input bit v);
        @(negedge clk);
        db_in = v;
        @(posedge clk);
        #1;
        samp.push_back(v);
        if (short_press)  begin obs_e.push_back(samp.size() - 1); obs_k.push_back(1); end
        if (long_press)   begin obs_e.push_back(samp.size() - 1); obs_k.push_back(2); end
        if (double_press) begin obs_e.push_back(samp.size() - 1); obs_k.push_back(3); end
        if (int'(short_press) + int'(long_press) + int'(double_press) > 1) multi_hot++;
    endtask

    task automatic drive(input bit v, input int n);
        repeat (n) step(v);
    endtask

    // Reference model: split the sampled level into presses (rise index,
    // held length) and classify them press by press from the timing rules.
    task automatic run_model();
        int rs[$];
        int ps[$];
        int n;
        int k;
        exp_e.delete();
        exp_k.delete();
        n = samp.size();
        for (int i = 0; i < n; i++) begin
            if (samp[i] && (i == 0 || !samp[i-1])) begin
                int j;
                j = i;
                while (j < n && samp[j]) j++;
                rs.push_back(i);
                ps.push_back(j - i);
            end
        end
        k = 0;
        while (k < rs.size()) begin
            int f;
            f = rs[k] + ps[k];
            if (ps[k] > LONG) begin
                exp_e.push_back(rs[k] + LONG); exp_k.push_back(2);
                k++;
            end else if (f >= n) begin
                k++;
            end else if (k + 1 < rs.size() && rs[k+1] - f <= DCK) begin
                exp_e.push_back(rs[k+1]); exp_k.push_back(3);
                k += 2;
            end else begin
                if (f + DCK < n) begin exp_e.push_back(f + DCK); exp_k.push_back(1); end
                k++;
            end
        end
        exp_count = exp_count + 8'(exp_e.size());
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        db_in   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            db_in = ~db_in;
            @(posedge clk);
            #1;
            total++;
            if ({short_press, long_press, double_press, press_count, busy} !== 12'd0) begin
                $display("FAIL reset_outputs cycle %0d: got %b %b %b %0d %b want all 0",
                         c, short_press, long_press, double_press, press_count, busy);
            end else passed++;
        end
        @(negedge clk);
        db_in = 1'b0;
        #2 n_reset = 1'b1;
        exp_count = 8'd0;
    endtask

    task automatic test_short();
        begin_scn();
        drive(1'b1, 100);
        drive(1'b0, 400);
        run_model();
        total++;
        if (obs_e.size() != 1 || obs_k[0] !== 1 || obs_e[0] !== 100 + DCK) begin
            $display("FAIL short_timing: got %0d events first at %0d want one short at %0d",
                     obs_e.size(), (obs_e.size() > 0) ? obs_e[0] : -1, 100 + DCK);
        end else passed++;
        total++;
        if (press_count !== exp_count || busy !== 1'b0 || multi_hot != 0) begin
            $display("FAIL short_end: got count %0d busy %b multi %0d want count %0d busy 0 multi 0",
                     press_count, busy, multi_hot, exp_count);
        end else passed++;
    endtask

    task automatic test_long();
        begin_scn();
        drive(1'b1, 2000);
        drive(1'b0, DCK + 10);
        run_model();
        total++;
        if (obs_e.size() != 1 || obs_k[0] !== 2 || obs_e[0] !== LONG) begin
            $display("FAIL long_timing: got %0d events first at %0d want one long at %0d",
                     obs_e.size(), (obs_e.size() > 0) ? obs_e[0] : -1, LONG);
        end else passed++;
        total++;
        if (press_count !== exp_count || busy !== 1'b0 || multi_hot != 0) begin
            $display("FAIL long_end: got count %0d busy %b multi %0d want count %0d busy 0 multi 0",
                     press_count, busy, multi_hot, exp_count);
        end else passed++;
    endtask

    // Holds straddling the long threshold: LONG samples is still short,
    // LONG+1 samples becomes long.
    task automatic test_long_boundary();
        int lens[3] = '{LONG - 1, LONG, LONG + 1};
        foreach (lens[t]) begin
            begin_scn();
            drive(1'b1, lens[t]);
            drive(1'b0, DCK + 10);
            run_model();
            total++;
            if (obs_e.size() != exp_e.size()) begin
                $display("FAIL boundary_len%0d events: got %0d want %0d", lens[t], obs_e.size(), exp_e.size());
            end else passed++;
            for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
                total++;
                if (obs_e[i] !== exp_e[i] || obs_k[i] !== exp_k[i]) begin
                    $display("FAIL boundary_len%0d ev%0d: got kind %0d at %0d want kind %0d at %0d",
                             lens[t], i, obs_k[i], obs_e[i], exp_k[i], exp_e[i]);
                end else passed++;
            end
            total++;
            if (press_count !== exp_count || busy !== 1'b0 || multi_hot != 0) begin
                $display("FAIL boundary_len%0d end: got count %0d busy %b want count %0d busy 0",
                         lens[t], press_count, busy, exp_count);
            end else passed++;
        end
    endtask

    // Gap DCK still lands on the last window cycle, where a new press wins
    // over expiry; gap DCK+1 gives a short then a fresh press.
    task automatic test_double();
        int gaps[4] = '{100, DCK - 1, DCK, DCK + 1};
        foreach (gaps[t]) begin
            begin_scn();
            drive(1'b1, 50);
            drive(1'b0, gaps[t]);
            drive(1'b1, 50);
            drive(1'b0, DCK + 10);
            run_model();
            total++;
            if (obs_e.size() != exp_e.size()) begin
                $display("FAIL double_gap%0d events: got %0d want %0d", gaps[t], obs_e.size(), exp_e.size());
            end else passed++;
            for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
                total++;
                if (obs_e[i] !== exp_e[i] || obs_k[i] !== exp_k[i]) begin
                    $display("FAIL double_gap%0d ev%0d: got kind %0d at %0d want kind %0d at %0d",
                             gaps[t], i, obs_k[i], obs_e[i], exp_k[i], exp_e[i]);
                end else passed++;
            end
            total++;
            if (press_count !== exp_count || busy !== 1'b0 || multi_hot != 0) begin
                $display("FAIL double_gap%0d end: got count %0d busy %b want count %0d busy 0",
                         gaps[t], press_count, busy, exp_count);
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        begin_scn();
        drive(1'b1, 500);
        total++;
        if (obs_e.size() != 0 || busy !== 1'b1) begin
            $display("FAIL reset_mid_pre: got %0d events busy %b want 0 events busy 1", obs_e.size(), busy);
        end else passed++;
        #2 n_reset = 1'b0;
        #1;
        total++;
        if ({short_press, long_press, double_press, press_count, busy} !== 12'd0) begin
            $display("FAIL reset_mid_async: got %b %b %b %0d %b want all 0",
                     short_press, long_press, double_press, press_count, busy);
        end else passed++;
        exp_count = 8'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if ({short_press, long_press, double_press, press_count, busy} !== 12'd0) begin
                $display("FAIL reset_mid_hold: got %b %b %b %0d %b want all 0",
                         short_press, long_press, double_press, press_count, busy);
            end else passed++;
        end
        // Release with the button still held: the first edge starts a press.
        @(posedge clk);
        #2 n_reset = 1'b1;
        begin_scn();
        drive(1'b1, 100);
        drive(1'b0, DCK + 10);
        run_model();
        total++;
        if (obs_e.size() != exp_e.size() || (obs_e.size() > 0 && (obs_e[0] !== exp_e[0] || obs_k[0] !== exp_k[0]))) begin
            $display("FAIL reset_mid_after: got %0d events first at %0d want %0d events first at %0d",
                     obs_e.size(), (obs_e.size() > 0) ? obs_e[0] : -1, exp_e.size(), (exp_e.size() > 0) ? exp_e[0] : -1);
        end else passed++;
        total++;
        if (press_count !== exp_count || busy !== 1'b0) begin
            $display("FAIL reset_mid_end: got count %0d busy %b want count %0d busy 0", press_count, busy, exp_count);
        end else passed++;
    endtask

    task automatic test_random();
        begin_scn();
        for (int n = 0; n < 16; n++) begin
            int p;
            int g;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0) p = $urandom_range(LONG - 2, LONG + 2);
            else p = $urandom_range(1, 120);
            sel = $urandom_range(0, 4);
            case (sel)
                0: g = 1;
                1: g = DCK - 1;
                2: g = DCK;
                3: g = DCK + 1;
                default: g = $urandom_range(1, 400);
            endcase
            drive(1'b1, p);
            drive(1'b0, g);
        end
        drive(1'b0, DCK + 10);
        run_model();
        total++;
        if (obs_e.size() != exp_e.size()) begin
            $display("FAIL random events: got %0d want %0d", obs_e.size(), exp_e.size());
        end else passed++;
        for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
            total++;
            if (obs_e[i] !== exp_e[i] || obs_k[i] !== exp_k[i]) begin
                $display("FAIL random ev%0d: got kind %0d at %0d want kind %0d at %0d",
                         i, obs_k[i], obs_e[i], exp_k[i], exp_e[i]);
            end else passed++;
        end
        total++;
        if (press_count !== exp_count || busy !== 1'b0 || multi_hot != 0) begin
            $display("FAIL random_end: got count %0d busy %b multi %0d want count %0d busy 0 multi 0",
                     press_count, busy, multi_hot, exp_count);
        end else passed++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        db_in = 1'b0;
        #2 n_reset = 1'b0;
        @(posedge clk);
        #2 n_reset = 1'b1;
        exp_count = 8'd0;
        begin_scn();
        for (int n = 0; n < 256; n++) begin
            drive(1'b1, 1);
            drive(1'b0, DCK + 1);
            if (n == 254) begin
                total++;
                if (press_count !== 8'd255) begin
                    $display("FAIL wrap_255: got %0d want 255", press_count);
                end else passed++;
            end
        end
        run_model();
        total++;
        if (obs_e.size() != exp_e.size() || obs_e.size() != 256) begin
            $display("FAIL wrap_events: got %0d want %0d", obs_e.size(), exp_e.size());
        end else passed++;
        total++;
        if (press_count !== 8'd0 || press_count !== exp_count || busy !== 1'b0) begin
            $display("FAIL wrap_zero: got count %0d busy %b want count 0 busy 0", press_count, busy);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_long_boundary();
        test_double();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
